// File: rtl/parallel_serial.sv
// Eight-line serial front-end capture: packs NDATA samples into 36-bit FIFO words.
// Define PS_HEADER_WORD_EN to emit a frame header word carrying a frame counter.
module parallel_serial #(
  parameter int NDATA = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fd0,
  input  logic        fd1,
  input  logic        fd2,
  input  logic        fd3,
  input  logic        fd4,
  input  logic        fd5,
  input  logic        fd6,
  input  logic        fd7,
  input  logic        mode,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [35:0] data_out
);

  localparam int CW = $clog2(NDATA + 1);
  localparam logic [CW-1:0] LAST = CW'(NDATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    slot_q, slot_d;
  logic [31:0]   pack_q, pack_d;
  logic [35:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ovf_q, ovf_d;
  logic          wr_q, wr_d;
  logic [35:0]   dout_q, dout_d;
`ifdef PS_HEADER_WORD_EN
  logic [15:0]   frame_q, frame_d;
`endif

  logic [7:0]  samp8;
  logic [31:0] placed;
  logic [31:0] word;
  logic        last_smp;
  logic        word_done;
  logic        nw_vld;
  logic [35:0] nw;

  assign samp8 = {fd7, fd6, fd5, fd4, fd3, fd2, fd1, fd0};
  assign last_smp = (cnt_q == LAST);

  // Earliest sample lands in the MSBs; later ones fill downward.
  always_comb begin
    if (mode_q)
      placed = {24'h0, samp8} << {2'd3 - slot_q[1:0], 3'b000};
    else
      placed = {31'h0, fd0} << ~slot_q;
  end

  assign word = pack_q | placed;
  assign word_done = last_smp |
    (mode_q ? (slot_q[1:0] == 2'd3) : (slot_q == 5'd31));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    wr_d       = 1'b0;
    dout_d     = dout_q;
    nw_vld     = 1'b0;
    nw         = '0;
`ifdef PS_HEADER_WORD_EN
    frame_d    = frame_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          mode_d  = mode;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          slot_d  = '0;
          pack_d  = '0;
`ifdef PS_HEADER_WORD_EN
          nw_vld  = 1'b1;
          nw      = {4'hF, 16'h0, frame_q};
`endif
        end
      end
      CAPTURE: begin
        cnt_d = cnt_q + CW'(1);
        if (word_done) begin
          nw_vld = 1'b1;
          nw     = {last_smp, ovf_q, mode_q, 1'b0, word};
          pack_d = '0;
          slot_d = '0;
        end else begin
          pack_d = word;
          slot_d = slot_q + 5'd1;
        end
      end
      FLUSH: begin
      end
      default: state_d = IDLE;
    endcase

    // One-entry skid: pending word always goes out before a new one.
    if (pend_vld_q) begin
      if (!fifo_full) begin
        wr_d       = 1'b1;
        dout_d     = pend_q;
        pend_vld_d = nw_vld;
        if (nw_vld)
          pend_d = nw;
      end else if (nw_vld) begin
        ovf_d = 1'b1;
      end
    end else if (nw_vld) begin
      if (!fifo_full) begin
        wr_d   = 1'b1;
        dout_d = nw;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = nw;
      end
    end

    if ((state_q == CAPTURE && last_smp) ||
        (state_q == FLUSH && !pend_vld_d)) begin
      state_d = pend_vld_d ? FLUSH : IDLE;
`ifdef PS_HEADER_WORD_EN
      if (!pend_vld_d)
        frame_d = frame_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      slot_q     <= '0;
      pack_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
`ifdef PS_HEADER_WORD_EN
      frame_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      wr_q       <= wr_d;
      dout_q     <= dout_d;
`ifdef PS_HEADER_WORD_EN
      frame_q    <= frame_d;
`endif
    end
  end

  assign fifo_wr_en = wr_q;
  assign data_out   = dout_q;

endmodule

// File: tb/tb_parallel_serial.sv
// Scoreboard bench for parallel_serial (NDATA=10).
// Expected FIFO words are queued at stimulus time and popped on each write.
module tb_parallel_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  fd;
  logic        mode;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [35:0] data_out;

  int errors = 0;
  int checks = 0;
  int nwr    = 0;
  logic [35:0] exp_q[$];
  logic [15:0] fcnt = 16'd0;

`ifdef PS_HEADER_WORD_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  parallel_serial #(.NDATA(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fd0       (fd[0]),
    .fd1       (fd[1]),
    .fd2       (fd[2]),
    .fd3       (fd[3]),
    .fd4       (fd[4]),
    .fd5       (fd[5]),
    .fd6       (fd[6]),
    .fd7       (fd[7]),
    .mode      (mode),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(output logic wr);
    logic fp;
    logic [35:0] e;
    fp = fifo_full;
    @(posedge clk);
    #1;
    wr = fifo_wr_en;
    if (fp) begin
      checks++;
      if (fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL full_block wr_en=%b required 0", fifo_wr_en);
      end
    end else if (fifo_wr_en === 1'b1) begin
      nwr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write data_out=%h required none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL word data_out=%h required %h", data_out, e);
        end
      end
    end
  endtask

  task automatic idle_steps(input int n);
    logic w;
    for (int i = 0; i < n; i++) step(w);
  endtask

  task automatic start_frame(input logic m);
    logic w;
    mode  = m;
    start = 1'b1;
    if (HDR != 0) exp_q.push_back({4'hF, 16'h0, fcnt});
    step(w);
    start = 1'b0;
  endtask

  task automatic end_frame(input string name, input int exp_wr);
    checks++;
    if (exp_q.size() != 0 || nwr != exp_wr) begin
      errors++;
      $display("FAIL %s writes=%0d left=%0d required writes=%0d left=0",
               name, nwr, exp_q.size(), exp_wr);
    end
    exp_q.delete();
    nwr = 0;
  endtask

  task automatic test_reset();
    logic w;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      step(w);
      checks++;
      if (fifo_wr_en !== 1'b0 || data_out !== 36'h0) begin
        errors++;
        $display("FAIL reset_hold wr_en=%b data=%h required 0 0",
                 fifo_wr_en, data_out);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(w);
      checks++;
      if (fifo_wr_en !== 1'b0 || data_out !== 36'h0) begin
        errors++;
        $display("FAIL reset_idle wr_en=%b data=%h required 0 0",
                 fifo_wr_en, data_out);
      end
    end
    end_frame("reset_writes", 0);
  endtask

  task automatic test_mode8(input logic fd3_drop);
    logic w;
    fd = 8'hBF;
    start_frame(1'b1);
    exp_q.push_back(36'h2_BFBFBFBF);
    if (fd3_drop) begin
      exp_q.push_back(36'h2_BFB7B7B7);
      exp_q.push_back(36'hA_B7B70000);
    end else begin
      exp_q.push_back(36'h2_BFBFBFBF);
      exp_q.push_back(36'hA_BFBF0000);
    end
    for (int i = 1; i <= 10; i++) begin
      if (fd3_drop && i >= 6) fd = 8'hB7;
      step(w);
      if (i == 4) begin
        checks++;
        if (w !== 1'b1) begin
          errors++;
          $display("FAIL first_latency wr_en=%b required 1", w);
        end
      end
    end
    idle_steps(4);
    fcnt++;
    end_frame(fd3_drop ? "mode8_fd3" : "mode8", 3 + HDR);
  endtask

  task automatic test_mode1();
    logic w;
    fd = 8'h01;
    start_frame(1'b0);
    exp_q.push_back(36'h8_FFC00000);
    for (int i = 1; i <= 10; i++) begin
      step(w);
      checks++;
      if (w !== (i == 10)) begin
        errors++;
        $display("FAIL mode1_timing sample=%0d wr_en=%b required %b",
                 i, w, (i == 10));
      end
    end
    idle_steps(4);
    fcnt++;
    end_frame("mode1", 1 + HDR);
  endtask

  task automatic test_full_overflow();
    logic w;
    fd = 8'hBF;
    start_frame(1'b1);
    exp_q.push_back(36'h2_BFBFBFBF);
    exp_q.push_back(36'hE_BFBF0000);
    for (int i = 1; i <= 10; i++) begin
      fifo_full = (i <= 8);
      step(w);
    end
    fifo_full = 1'b0;
    idle_steps(4);
    fcnt++;
    end_frame("full_overflow", 2 + HDR);
  endtask

  task automatic test_back_to_back();
    logic w;
    fd = 8'hBF;
    start_frame(1'b1);
    exp_q.push_back(36'h2_BFBFBFBF);
    exp_q.push_back(36'h2_BFBFBFBF);
    exp_q.push_back(36'hA_BFBF0000);
    for (int i = 1; i <= 10; i++) begin
      start = (i == 5);
      step(w);
    end
    start = 1'b0;
    idle_steps(6);
    fcnt++;
    end_frame("restart_ignored", 3 + HDR);
  endtask

  task automatic test_reset_mid();
    logic w;
    fd = 8'hBF;
    start_frame(1'b1);
    exp_q.push_back(36'h2_BFBFBFBF);
    for (int i = 1; i <= 6; i++) step(w);
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || data_out !== 36'h0) begin
      errors++;
      $display("FAIL async_reset wr_en=%b data=%h required 0 0",
               fifo_wr_en, data_out);
    end
    fcnt = 16'd0;
    idle_steps(3);
    rst = 1'b1;
    idle_steps(12);
    end_frame("reset_mid", 1 + HDR);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    fd        = 8'h00;
    mode      = 1'b0;
    fifo_full = 1'b0;
    test_reset();
    test_mode8(1'b0);
    test_mode8(1'b1);
    test_mode1();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
